int_calc_arbiter: RTL
=====================

Name: int_calc_arbiter

Overview:
- Shares one non-pipelined log2 normaliser (int_calc-style: in_valid/in_ready in, out_valid/out_ready with int_part/data_out out) among NUM_CH requesting channels, e.g. per-element envelope paths.
- Grants round-robin and keeps one transaction in flight.
- Routes each result back to the channel that issued it.
- Guards against a hung normaliser with a watchdog.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_WIDTH, 16, sample width.
- FRAC_WIDTH, 16, normaliser fraction width.
- NORM_WIDTH, FRAC_WIDTH+1, normaliser mantissa width.
- SHIFT_WIDTH, $clog2(DATA_WIDTH), normaliser int_part width.
- CH_WIDTH, $clog2(NUM_CH), channel index width.
- TIMEOUT, 64, maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel enable mask; a disabled channel is never granted.
- req_valid  in  NUM_CH  per-channel sample valid.
- req_ready  out  NUM_CH  per-channel accept, combinational one-hot.
- req_data  in  NUM_CH*DATA_WIDTH  flattened samples; channel k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- norm_in_valid  out  1  sample valid to normaliser.
- norm_in_ready  in  1  normaliser accept.
- norm_data  out  DATA_WIDTH  sample to normaliser.
- norm_out_valid  in  1  normaliser result valid.
- norm_out_ready  out  1  result accept to normaliser.
- norm_int_part  in  SHIFT_WIDTH  normaliser exponent.
- norm_data_out  in  NORM_WIDTH  normaliser mantissa.
- res_valid  out  NUM_CH  one-hot result valid, owning channel only.
- res_ready  in  NUM_CH  per-channel result accept.
- res_ch  out  CH_WIDTH  index of the result's owner.
- res_int_part  out  SHIFT_WIDTH  returned exponent.
- res_data  out  NORM_WIDTH  returned mantissa.
- res_err  out  1  result aborted by watchdog.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- State machine: IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
- Reset (asynchronous, reset=0):
  - state=IDLE.
  - last_grant=NUM_CH-1, so ch0 has first priority.
  - All outputs 0: norm_in_valid, norm_data, res_valid, res_ch, res_int_part, res_data, res_err, busy.
  - Timer cleared.
  - Reset mid-transaction abandons it with no result returned. The normaliser must share the reset domain.
- Eligibility: channel k is eligible when req_valid[k] & ch_en[k].
- IDLE:
  - Winner g is the first eligible channel scanning from last_grant+1 upward, wrapping modulo NUM_CH.
  - req_ready = onehot(g) only in IDLE with at least one eligible channel; otherwise 0.
  - req_ready never depends on req_valid of other channels beyond selecting g.
  - On acceptance: latch sample, g -> grant/res_ch, last_grant <= g, state -> ISSUE.
  - No eligible channel: stay in IDLE.
- ISSUE:
  - norm_in_valid=1 (registered, asserted on entry) with norm_data = latched sample, held stable.
  - On norm_in_valid & norm_in_ready: deassert norm_in_valid next cycle, clear timer, -> WAIT.
- WAIT:
  - norm_out_ready=1 (combinational, WAIT only).
  - On norm_out_valid: capture norm_int_part and norm_data_out, res_err=0, -> RETURN.
  - Timer increments each WAIT cycle.
  - If timer reaches TIMEOUT-1 without norm_out_valid: res_int_part=0, res_data=0, res_err=1, -> RETURN.
  - If norm_out_valid arrives on the timeout cycle, the valid result wins.
- RETURN:
  - res_valid = onehot(res_ch); data held stable until accepted.
  - On res_ready[res_ch]: res_valid=0 next cycle, -> IDLE.
  - res_ready of other channels is ignored.
- Throughput: minimum 3 arbiter cycles plus normaliser latency plus downstream stall per sample. No back-to-back overlap.
- ch_en changes take effect only at the next IDLE arbitration. A granted transaction always completes.
- Output stability: res_* are registered and never change while res_valid is high.

Test Plan:
- Single request: ch2 sends 0x0100; stub normaliser answers 2 cycles later with int_part=8, data_out=0x10000 -> res_valid=4'b0100, res_ch=2, res_int_part=8, res_data=0x10000, res_err=0; busy falls after res_ready[2].
- Round-robin fairness: all four channels hold req_valid continuously from reset -> grants in order 0,1,2,3,0,1; each req_ready pulse is exactly one cycle.
- Enable mask: ch_en=4'b1010 with all requests valid -> only ch1 and ch3 are granted, alternating; req_ready[0] and req_ready[2] stay 0.
- Backpressure: norm_in_ready low for 5 cycles -> norm_data stable and norm_in_valid held; res_ready[1] low for 10 cycles -> res_* frozen, no new grant.
- Watchdog: stub never raises norm_out_valid -> after TIMEOUT=64 WAIT cycles, res_valid for the owning channel with res_err=1 and res_data=0; the next request is then served normally.
- Async reset during WAIT (reset pulsed low mid-cycle) -> all outputs 0 immediately, no result for the aborted channel, and ch0 is granted first afterwards.

Source files
------------

// File: rtl/int_calc_arbiter.sv
// Round-robin arbiter sharing one non-pipelined log2 normaliser among NUM_CH channels.
// Keeps a single transaction in flight and routes each result back to its issuing channel.
// A watchdog aborts a hung normaliser and returns an error result.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   ch_en_i                    per-channel enable mask, sampled at arbitration only
//   req_valid_i/req_ready_o    per-channel sample handshake (ready is one-hot)
//   req_data_i                 flattened samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   norm_in_valid_o/_ready_i   sample handshake towards the normaliser
//   norm_data_o                sample to the normaliser
//   norm_out_valid_i/_ready_o  result handshake from the normaliser
//   norm_int_part_i            normaliser exponent
//   norm_data_out_i            normaliser mantissa
//   res_valid_o/res_ready_i    one-hot result handshake towards the owning channel
//   res_ch_o                   owner index of the current result
//   res_int_part_o, res_data_o returned exponent and mantissa
//   res_err_o                  result was aborted by the watchdog
//   busy_o                     a transaction is in progress
module int_calc_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH  = 16,
  parameter int unsigned NORM_WIDTH  = FRAC_WIDTH + 1,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int unsigned CH_WIDTH    = $clog2(NUM_CH),
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            ch_en_i,
  input  logic [NUM_CH-1:0]            req_valid_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data_i,
  output logic                         norm_in_valid_o,
  input  logic                         norm_in_ready_i,
  output logic [DATA_WIDTH-1:0]        norm_data_o,
  input  logic                         norm_out_valid_i,
  output logic                         norm_out_ready_o,
  input  logic [SHIFT_WIDTH-1:0]       norm_int_part_i,
  input  logic [NORM_WIDTH-1:0]        norm_data_out_i,
  output logic [NUM_CH-1:0]            res_valid_o,
  input  logic [NUM_CH-1:0]            res_ready_i,
  output logic [CH_WIDTH-1:0]          res_ch_o,
  output logic [SHIFT_WIDTH-1:0]       res_int_part_o,
  output logic [NORM_WIDTH-1:0]        res_data_o,
  output logic                         res_err_o,
  output logic                         busy_o
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT + 1);
  localparam logic [TimerWidth-1:0] TimerMax = TimerWidth'(TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] OneHot0 = {{(NUM_CH - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

  state_e                  state_q, state_d;
  logic [CH_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [CH_WIDTH-1:0]     ch_q, ch_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    in_valid_q, in_valid_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic [SHIFT_WIDTH-1:0]  int_part_q, int_part_d;
  logic [NORM_WIDTH-1:0]   res_data_q, res_data_d;
  logic                    err_q, err_d;

  logic [NUM_CH-1:0]       eligible;
  logic                    grant_found;
  logic [CH_WIDTH-1:0]     grant_idx;
  logic [CH_WIDTH-1:0]     cand;
  logic [DATA_WIDTH-1:0]   grant_data;

  assign eligible = req_valid_i & ch_en_i;

  // Scan from the channel after the last winner, wrapping, and take the first eligible one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CH_WIDTH'((32'(last_grant_q) + i) % NUM_CH);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_idx == CH_WIDTH'(k)) begin
        grant_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    data_d       = data_q;
    in_valid_d   = in_valid_q;
    timer_d      = timer_q;
    int_part_d   = int_part_q;
    res_data_d   = res_data_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          data_d       = grant_data;
          ch_d         = grant_idx;
          last_grant_d = grant_idx;
          in_valid_d   = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (norm_in_ready_i) begin
          in_valid_d = 1'b0;
          timer_d    = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        // A real result arriving on the timeout cycle takes precedence over the abort.
        if (norm_out_valid_i) begin
          int_part_d = norm_int_part_i;
          res_data_d = norm_data_out_i;
          err_d      = 1'b0;
          state_d    = StReturn;
        end else if (timer_q == TimerMax) begin
          int_part_d = '0;
          res_data_d = '0;
          err_d      = 1'b1;
          state_d    = StReturn;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end
      StReturn: begin
        if (res_ready_i[ch_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= CH_WIDTH'(NUM_CH - 1);
      ch_q         <= '0;
      data_q       <= '0;
      in_valid_q   <= 1'b0;
      timer_q      <= '0;
      int_part_q   <= '0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      data_q       <= data_d;
      in_valid_q   <= in_valid_d;
      timer_q      <= timer_d;
      int_part_q   <= int_part_d;
      res_data_q   <= res_data_d;
      err_q        <= err_d;
    end
  end

  assign req_ready_o      = (state_q == StIdle && grant_found) ? (OneHot0 << grant_idx) : '0;
  assign norm_in_valid_o  = in_valid_q;
  assign norm_data_o      = data_q;
  assign norm_out_ready_o = (state_q == StWait);
  assign res_valid_o      = (state_q == StReturn) ? (OneHot0 << ch_q) : '0;
  assign res_ch_o         = ch_q;
  assign res_int_part_o   = int_part_q;
  assign res_data_o       = res_data_q;
  assign res_err_o        = err_q;
  assign busy_o           = (state_q != StIdle);

endmodule
